// File: rtl/apb_ctrl_ws.sv
// AHB-to-APB bridge with wait-state support, per-transfer timeout and a
// two-cycle AHB error response. All outputs are registered on Hclk.
module apb_ctrl_ws #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int NSLV    = 3,
  parameter int SEL_LSB = 12,
  parameter int TIMEOUT = 16
) (
  input  logic            Hclk,
  input  logic            Hreset,
  input  logic            valid,
  input  logic            Hwrite,
  input  logic [AW-1:0]   Haddr,
  input  logic [DW-1:0]   Hwdata,
  output logic            Hreadyout,
  output logic            Hresp,
  output logic [DW-1:0]   Hrdata,
  output logic [AW-1:0]   Paddr,
  output logic [DW-1:0]   Pwdata,
  output logic            Pwrite,
  output logic [NSLV-1:0] Pselx,
  output logic            Penable,
  input  logic            Pready,
  input  logic            Pslverr,
  input  logic [DW-1:0]   Prdata
);

  localparam int SW = (NSLV > 1) ? $clog2(NSLV) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [SW:0]   NSLV_L = NSLV[SW:0];
  localparam logic [CW-1:0] TMAX   = CW'(TIMEOUT - 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] WWAIT  = 3'd1;
  localparam logic [2:0] SETUP  = 3'd2;
  localparam logic [2:0] ACCESS = 3'd3;
  localparam logic [2:0] ERR1   = 3'd4;
  localparam logic [2:0] ERR2   = 3'd5;

  logic [2:0]    state;
  logic [SW-1:0] idx;
  logic [SW-1:0] haddr_idx;
  logic          idx_ok;
  logic [CW-1:0] cnt;

  assign haddr_idx = Haddr[SEL_LSB +: SW];
  assign idx_ok    = ({1'b0, haddr_idx} < NSLV_L);

  function automatic logic [NSLV-1:0] onehot(input logic [SW-1:0] i);
    return NSLV'(1) << i;
  endfunction

  always_ff @(posedge Hclk or posedge Hreset) begin
    if (Hreset) begin
      state     <= IDLE;
      idx       <= '0;
      cnt       <= '0;
      Hreadyout <= 1'b1;
      Hresp     <= 1'b0;
      Hrdata    <= '0;
      Paddr     <= '0;
      Pwdata    <= '0;
      Pwrite    <= 1'b0;
      Pselx     <= '0;
      Penable   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // Hreadyout is always high here, so valid alone qualifies acceptance
          if (valid) begin
            Hreadyout <= 1'b0;
            if (!idx_ok) begin
              state <= ERR1;
              Hresp <= 1'b1;
            end else begin
              Paddr  <= Haddr;
              Pwrite <= Hwrite;
              idx    <= haddr_idx;
              if (Hwrite) begin
                state <= WWAIT;
              end else begin
                state <= SETUP;
                Pselx <= onehot(haddr_idx);
                cnt   <= '0;
              end
            end
          end
        end
        WWAIT: begin
          Pwdata <= Hwdata;
          state  <= SETUP;
          Pselx  <= onehot(idx);
          cnt    <= '0;
        end
        SETUP: begin
          Penable <= 1'b1;
          state   <= ACCESS;
        end
        ACCESS: begin
          // Pready wins over the timeout on the final permitted cycle
          if (Pready) begin
            Pselx   <= '0;
            Penable <= 1'b0;
            if (!Pwrite) Hrdata <= Prdata;
            if (Pslverr) begin
              state <= ERR1;
              Hresp <= 1'b1;
            end else begin
              state     <= IDLE;
              Hreadyout <= 1'b1;
            end
          end else if (cnt == TMAX) begin
            Pselx   <= '0;
            Penable <= 1'b0;
            state   <= ERR1;
            Hresp   <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ERR1: begin
          state     <= ERR2;
          Hreadyout <= 1'b1;
        end
        ERR2: begin
          state <= IDLE;
          Hresp <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          Hreadyout <= 1'b1;
          Hresp     <= 1'b0;
          Pselx     <= '0;
          Penable   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_ctrl_ws.sv
// Bench for apb_ctrl_ws: directed vector table, randomized transfers checked
// against a transaction-level model, and a mid-transfer reset sequence.
module tb_apb_ctrl_ws;

  localparam int TO = 16;

  logic        Hclk = 1'b0;
  logic        Hreset, valid, Hwrite;
  logic [31:0] Haddr, Hwdata;
  logic        Hreadyout, Hresp;
  logic [31:0] Hrdata, Paddr, Pwdata;
  logic        Pwrite;
  logic [2:0]  Pselx;
  logic        Penable, Pready, Pslverr;
  logic [31:0] Prdata;

  apb_ctrl_ws #(.AW(32), .DW(32), .NSLV(3), .SEL_LSB(12), .TIMEOUT(TO)) dut (
    .Hclk(Hclk), .Hreset(Hreset), .valid(valid), .Hwrite(Hwrite),
    .Haddr(Haddr), .Hwdata(Hwdata), .Hreadyout(Hreadyout), .Hresp(Hresp),
    .Hrdata(Hrdata), .Paddr(Paddr), .Pwdata(Pwdata), .Pwrite(Pwrite),
    .Pselx(Pselx), .Penable(Penable), .Pready(Pready), .Pslverr(Pslverr),
    .Prdata(Prdata)
  );

  always #5 Hclk = ~Hclk;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int unsigned waits;    // ACCESS cycles with Pready low before Pready rises
    logic        slverr;
    logic [31:0] prdata;
    logic [2:0]  e_sel;
    int unsigned e_acc;
    logic        e_err;
    logic [31:0] e_rdata;
    int unsigned e_low;    // cycles with Hreadyout low
  } vec_t;

  int unsigned nvec = 0;
  int unsigned nerr = 0;
  logic [31:0] last_rd = '0;
  vec_t        tbl[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Transaction-level reference: outcome follows directly from index validity,
  // wait count vs the timeout limit, and the slave error flag.
  function automatic void model(inout vec_t v);
    int unsigned i;
    i = 32'(v.addr[13:12]);
    if (i >= 3) begin
      v.e_sel = '0;
      v.e_acc = 0;
      v.e_err = 1'b1;
      v.e_low = 1;
    end else begin
      v.e_sel = 3'(1 << i);
      if (v.waits >= TO) begin
        v.e_acc = TO;
        v.e_err = 1'b1;
      end else begin
        v.e_acc = v.waits + 1;
        v.e_err = v.slverr;
        if (!v.wr) last_rd = v.prdata;
      end
      v.e_low = (v.wr ? 1 : 0) + 1 + v.e_acc + (v.e_err ? 1 : 0);
    end
    v.e_rdata = last_rd;
  endfunction

  task automatic xfer(input vec_t v, input string tag);
    int unsigned w, acc, setup, low, e1, e2;
    logic [2:0]  sel;
    logic        bad, done;
    w = 0;
    while (!Hreadyout && w < 50) begin
      @(negedge Hclk);
      w++;
    end
    if (w >= 50) chk({tag, "_ready_wait"}, 32'(Hreadyout), 32'd1);
    valid  = 1'b1;
    Hwrite = v.wr;
    Haddr  = v.addr;
    Hwdata = ~v.wdata;
    @(posedge Hclk);
    #1;
    valid  = 1'b0;
    Hwdata = v.wdata;
    acc = 0; setup = 0; low = 0; e1 = 0; e2 = 0; sel = '0; bad = 1'b0; done = 1'b0;
    for (int c = 0; c < 60 && !done; c++) begin
      @(negedge Hclk);
      if (Hreadyout && !Hresp) begin
        done  = 1'b1;
        valid = 1'b0;
      end else begin
        if (!Hreadyout) low++;
        if (Hresp && !Hreadyout) e1++;
        if (Hresp && Hreadyout) e2++;
        if ($countones(Pselx) > 1 || (Penable && Pselx == '0)) bad = 1'b1;
        if (Pselx != '0) begin
          if (sel == '0) sel = Pselx;
          else if (Pselx != sel) bad = 1'b1;
          if (Paddr != v.addr || Pwrite != v.wr || (v.wr && Pwdata != v.wdata)) bad = 1'b1;
          if (Penable) acc++;
          else setup++;
        end
        // valid must be ignored during the error response
        valid  = Hresp;
        Haddr  = $urandom;
        Hwrite = 1'($urandom);
      end
      Pready  = Penable ? (acc == v.waits + 1) : 1'($urandom);
      Pslverr = Penable ? (Pready && v.slverr) : 1'($urandom);
      Prdata  = Penable ? v.prdata : $urandom;
    end
    valid = 1'b0;
    chk({tag, "_complete"}, 32'(done), 32'd1);
    chk({tag, "_sel"}, 32'(sel), 32'(v.e_sel));
    chk({tag, "_setup_cycles"}, setup, (v.e_sel != '0) ? 32'd1 : 32'd0);
    chk({tag, "_access_cycles"}, acc, v.e_acc);
    chk({tag, "_err1_cycles"}, e1, 32'(v.e_err));
    chk({tag, "_err2_cycles"}, e2, 32'(v.e_err));
    chk({tag, "_hready_low"}, low, v.e_low);
    chk({tag, "_hrdata"}, Hrdata, v.e_rdata);
    chk({tag, "_apb_protocol"}, 32'(bad), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t v;
    logic bad;
    Hreset = 1'b1; valid = 1'b0; Hwrite = 1'b0; Haddr = '0; Hwdata = '0;
    Pready = 1'b0; Pslverr = 1'b0; Prdata = '0;

    //            wr    addr          wdata         wt  serr  prdata        sel     acc err   rdata         low
    tbl[0] = '{1'b0, 32'h0000_1004, 32'h0,        0,  1'b0, 32'hA5A5_0001, 3'b010, 1,  1'b0, 32'hA5A5_0001, 2};
    tbl[1] = '{1'b1, 32'h0000_2010, 32'hDEAD_BEEF, 3, 1'b0, 32'h1111_1111, 3'b100, 4,  1'b0, 32'hA5A5_0001, 6};
    tbl[2] = '{1'b0, 32'h0000_0008, 32'h0,        1,  1'b1, 32'h1234_5678, 3'b001, 2,  1'b1, 32'h1234_5678, 4};
    tbl[3] = '{1'b0, 32'h0000_3000, 32'h0,        0,  1'b0, 32'h5555_5555, 3'b000, 0,  1'b1, 32'h1234_5678, 1};
    tbl[4] = '{1'b0, 32'h0000_1000, 32'h0,        16, 1'b0, 32'h7777_7777, 3'b010, 16, 1'b1, 32'h1234_5678, 18};
    tbl[5] = '{1'b1, 32'h0000_3FFC, 32'h0BAD_0BAD, 0, 1'b0, 32'h0,        3'b000, 0,  1'b1, 32'h1234_5678, 1};
    tbl[6] = '{1'b1, 32'h0000_0000, 32'h0102_0304, 15, 1'b0, 32'h0,       3'b001, 16, 1'b0, 32'h1234_5678, 18};
    tbl[7] = '{1'b0, 32'h0000_2000, 32'h0,        0,  1'b0, 32'hCAFE_F00D, 3'b100, 1,  1'b0, 32'hCAFE_F00D, 2};

    repeat (3) @(negedge Hclk);
    chk("reset_hreadyout", 32'(Hreadyout), 32'd1);
    chk("reset_hresp",     32'(Hresp),     32'd0);
    chk("reset_pselx",     32'(Pselx),     32'd0);
    chk("reset_penable",   32'(Penable),   32'd0);
    chk("reset_pwrite",    32'(Pwrite),    32'd0);
    chk("reset_paddr",     Paddr,          32'd0);
    chk("reset_pwdata",    Pwdata,         32'd0);
    chk("reset_hrdata",    Hrdata,         32'd0);
    Hreset = 1'b0;
    @(negedge Hclk);

    for (int i = 0; i < 8; i++) begin
      xfer(tbl[i], $sformatf("dir%0d", i));
      last_rd = tbl[i].e_rdata;
    end

    for (int i = 0; i < 40; i++) begin
      int unsigned ix;
      ix       = $urandom_range(0, 3);
      v.wr     = 1'($urandom);
      v.addr   = ($urandom & ~32'h0000_3000) | (ix << 12);
      v.wdata  = $urandom;
      v.waits  = ($urandom_range(0, 7) == 0) ? $urandom_range(14, 17) : $urandom_range(0, 4);
      v.slverr = ($urandom_range(0, 3) == 0);
      v.prdata = $urandom;
      model(v);
      xfer(v, $sformatf("rnd%0d", i));
    end

    // Reset asserted between edges while a read sits in ACCESS
    valid = 1'b1; Hwrite = 1'b0; Haddr = 32'h0000_1000; Pready = 1'b0; Pslverr = 1'b0;
    @(posedge Hclk);
    #1 valid = 1'b0;
    repeat (3) @(negedge Hclk);
    chk("rst_pre_penable", 32'(Penable), 32'd1);
    #2 Hreset = 1'b1;
    #1;
    chk("rst_pselx",     32'(Pselx),     32'd0);
    chk("rst_penable",   32'(Penable),   32'd0);
    chk("rst_hreadyout", 32'(Hreadyout), 32'd1);
    chk("rst_hresp",     32'(Hresp),     32'd0);
    chk("rst_hrdata",    Hrdata,         32'd0);
    @(negedge Hclk);
    Hreset = 1'b0;
    bad = 1'b0;
    repeat (3) begin
      @(negedge Hclk);
      if (Pselx != '0 || Penable) bad = 1'b1;
    end
    chk("rst_quiet", 32'(bad), 32'd0);
    last_rd = '0;
    v = '{1'b0, 32'h0000_1008, 32'h0, 1, 1'b0, 32'h0F0F_A5A5, 3'b000, 0, 1'b0, 32'h0, 0};
    model(v);
    xfer(v, "post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/apb_ctrl_ws.md
APB_CTRL_WS -- requirements
Module: apb_ctrl_ws

Interface
REQ-001 Parameter AW, default 32, APB/AHB address width in bits.
REQ-002 Parameter DW, default 32, data width in bits (8, 16 or 32).
REQ-003 Parameter NSLV, default 3, number of APB slaves (1..16).
REQ-004 Parameter SEL_LSB, default 12, lowest Haddr bit of the slave-index field (field width clog2(NSLV), min 1).
REQ-005 Parameter TIMEOUT, default 16, maximum ACCESS cycles with Pready low before abort (>=2).
REQ-006 Ports: Hclk in 1 clock; Hreset in 1 reset; valid in 1 AHB transfer request (pre-qualified NONSEQ/SEQ); Hwrite in 1 direction; Haddr in AW address-phase address; Hwdata in DW data-phase write data.
REQ-007 Ports: Hreadyout out 1 ready; Hresp out 1 error; Hrdata out DW read data.
REQ-008 Ports: Paddr out AW; Pwdata out DW; Pwrite out 1; Pselx out NSLV one-hot select; Penable out 1; Pready in 1; Pslverr in 1; Prdata in DW.
REQ-009 One clock, Hclk; reset Hreset is asynchronous and active-high.

Function
REQ-010 All outputs SHALL be registered on Hclk rising edge.
REQ-011 FSM states: IDLE, WWAIT, SETUP, ACCESS, ERR1, ERR2.
REQ-012 Transfer accepted at a rising edge where valid=1 and Hreadyout=1; Haddr, Hwrite and slave index SHALL be captured at that edge.
REQ-013 Index = Haddr[SEL_LSB +: clog2(NSLV)]; index >= NSLV -> no APB access, go to ERR1.
REQ-014 Valid write accepted -> WWAIT for one cycle; Hwdata captured at end of WWAIT into Pwdata; then SETUP.
REQ-015 Valid read accepted -> SETUP directly.
REQ-016 SETUP: exactly one cycle; Pselx one-hot for index, Penable=0, Paddr/Pwrite stable; then ACCESS.
REQ-017 ACCESS: Penable=1; Paddr, Pwrite, Pwdata, Pselx held stable until completion.
REQ-018 Completion: rising edge in ACCESS with Pready=1; Pselx/Penable deasserted the following cycle.
REQ-019 Read completion: Prdata registered into Hrdata at completion edge; Hrdata holds value until next read completion.
REQ-020 Completion with Pslverr=0 -> Hreadyout=1, Hresp=0 next cycle; FSM to IDLE, or accepts next transfer that same cycle (back-to-back, no idle bubble on AHB side).
REQ-021 Completion with Pslverr=1 -> ERR1 (Hrdata still updated on reads).
REQ-022 Timeout counter: cleared on SETUP entry, increments each ACCESS cycle with Pready=0; reaching TIMEOUT-1 without Pready -> drop Pselx/Penable, go to ERR1.
REQ-023 ERR1: Hresp=1, Hreadyout=0, one cycle; ERR2: Hresp=1, Hreadyout=1, one cycle; then IDLE. valid ignored during ERR1/ERR2.
REQ-024 Hreadyout=0 from the cycle after acceptance through the final ACCESS/ERR1 cycle; Hresp=0 outside ERR1/ERR2.
REQ-025 Pselx SHALL never have more than one bit set; Penable=1 only while Pselx nonzero.
REQ-026 Pready, Pslverr SHALL be ignored outside ACCESS.

Reset
REQ-027 Hreset=1 asynchronously forces IDLE: Hreadyout=1, Hresp=0, Pselx=0, Penable=0, Pwrite=0, Paddr=0, Pwdata=0, Hrdata=0, timeout counter=0.
REQ-028 Reset mid-transfer SHALL abort it immediately with no further APB activity; first transfer accepted no earlier than the first edge after Hreset deasserts.

Verification
REQ-029 Read, Haddr=0x0000_1004, Pready=1 at first ACCESS, Prdata=0xA5A5_0001 -> Pselx=3'b010 SETUP 1 cycle, ACCESS 1 cycle, Hrdata=0xA5A5_0001, Hreadyout=1, Hresp=0.
REQ-030 Write Haddr=0x0000_2010, Hwdata=0xDEAD_BEEF, Pready low 3 cycles -> Pselx=3'b100, Pwrite=1, Pwdata=0xDEAD_BEEF held 4 ACCESS cycles, Hreadyout low throughout.
REQ-031 Read with Pslverr=1 at completion -> Hresp=1/Hreadyout=0 then Hresp=1/Hreadyout=1, then IDLE.
REQ-032 Haddr=0x0000_3000 (index 3, NSLV=3) -> Pselx stays 0, two-cycle error response.
REQ-033 Pready held 0, TIMEOUT=16 -> Penable drops after 16 ACCESS cycles, two-cycle error response.
REQ-034 Hreset asserted during ACCESS -> Pselx=0, Penable=0, Hreadyout=1 same cycle; next read completes normally.
